// File: rtl/uart_rx_sequencer.sv
// Oversampling UART receiver: start validation at mid-bit, LSB-first data,
// optional parity, stop check, and a one-word output holding register.
module uart_rx_sequencer #(
    parameter int OVERSAMPLING = 8,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLING);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    logic                 rx_meta_q, rx_s_q;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
    logic                 bit_end;

    // Line synchronizer resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        pe_d    = 1'b0;
        ov_d    = 1'b0;

        if (valid_q && rx_ready) valid_d = 1'b0;

        if (sample_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = CNT_W'(1);
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            idx_d   = '0;
                            perr_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_d   = '0;
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) state_d = PARITY_EN ? S_PARITY : S_STOP;
                        else                   idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_d   = '0;
                        perr_d  = rx_s_q != ((^shreg_q) ^ PARITY_ODD);
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        // A framing error wins over a pending parity mismatch.
                        if (!rx_s_q) begin
                            fe_d    = 1'b1;
                            state_d = S_WAIT;
                        end else if (perr_q) begin
                            pe_d    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_IDLE;
                            if (!valid_q || rx_ready) begin
                                data_d  = shreg_q;
                                valid_d = 1'b1;
                            end else begin
                                ov_d = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ov_q    <= ov_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign frame_error  = fe_q;
    assign parity_error = pe_q;
    assign overrun      = ov_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_sequencer.md
UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 Parameter OVERSAMPLING, default 8, ticks per bit; SHALL be even and >= 4.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_EN, default 0, 1 = parity bit present between data and stop.
REQ-004 Parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 clock  in  1  sole clock; all state changes on rising edge.
REQ-006 nreset  in  1  asynchronous, active-low reset.
REQ-007 sample_tick  in  1  oversample strobe from the baud generator, rate BAUDRATE*OVERSAMPLING; every clock it is high counts as one tick.
REQ-008 rx  in  1  asynchronous serial line, idle high.
REQ-009 rx_data  out  DATA_BITS  received word, LSB = first data bit on the line.
REQ-010 rx_valid  out  1  rx_data holds an unconsumed word.
REQ-011 rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
REQ-012 frame_error  out  1  one-clock pulse: stop bit sampled low.
REQ-013 parity_error  out  1  one-clock pulse: parity mismatch.
REQ-014 overrun  out  1  one-clock pulse: good word completed while previous word unconsumed.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); rx_s denotes its output, and only rx_s is used internally.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; tick counter cnt of width clog2(OVERSAMPLING); bit index of width clog2(DATA_BITS+1); all advance only on clocks with sample_tick=1.
REQ-018 IDLE: tick with rx_s=0 -> START, cnt=1 (detection tick = tick index 0).
REQ-019 START: on tick, if cnt==OVERSAMPLING/2-1, mid-bit check: rx_s=1 -> IDLE, glitch, no error flags; rx_s=0 -> DATA, cnt=0, bit index=0; otherwise cnt++.
REQ-020 DATA/PARITY/STOP: on tick, if cnt==OVERSAMPLING-1, sample rx_s and set cnt=0; otherwise cnt++.
REQ-021 DATA: each sample shifts into the word LSB-first; after the DATA_BITS-th sample -> PARITY if PARITY_EN=1, else STOP.
REQ-022 PARITY: sample is compared with XOR(data) (XNOR when PARITY_ODD=1); a mismatch is latched internally; -> STOP.
REQ-023 STOP sample rx_s=0: frame_error pulses on the following clock, word discarded, parity_error suppressed, -> WAIT_IDLE.
REQ-024 STOP sample rx_s=1 with parity mismatch latched: parity_error pulses, word discarded, -> IDLE.
REQ-025 STOP sample rx_s=1, no mismatch: if rx_valid=0 or rx_ready=1 that same clock, load rx_data and assert rx_valid on the next clock; otherwise pulse overrun, keep the old rx_data and rx_valid=1, and drop the new word; in all cases -> IDLE.
REQ-026 WAIT_IDLE: -> IDLE on the first tick with rx_s=1; no start detection occurs in this state.
REQ-027 rx_valid SHALL clear on the clock after rx_valid && rx_ready unless a new load coincides (REQ-025); rx_data SHALL stay stable while rx_valid=1.
REQ-028 Latency: rx_valid rises one clock after the stop-bit sampling tick, which is tick index OVERSAMPLING/2-1+OVERSAMPLING*(DATA_BITS+PARITY_EN+1).
REQ-029 sample_tick=0 SHALL freeze cnt, bit index and state; rx_ready handshakes SHALL proceed regardless of ticks.

Reset
REQ-030 While nreset=0: state IDLE, cnt=0, bit index=0, synchronizer=1, rx_data=0, rx_valid=0, frame_error=0, parity_error=0, overrun=0, busy=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no error pulse; the next frame after release SHALL be received normally.

Verification (OVERSAMPLING=8, DATA_BITS=8, sample_tick every 4 clocks unless stated)
REQ-032 Frame 0xA5, stop=1, rx_ready=1 -> rx_data=0xA5, rx_valid=1 one clock after tick index 75, consumed one clock later; busy falls at the same point.
REQ-033 rx low for 2 ticks then high -> START aborts at tick index 3, returns to IDLE, rx_valid, frame_error, parity_error and overrun stay 0.
REQ-034 Frame 0x3C with stop bit 0, line held low 20 more ticks -> one frame_error pulse, no rx_valid, busy high until the first tick with rx_s=1.
REQ-035 Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 with rx_valid=1, overrun pulses once at the end of the second frame; raising rx_ready then clears rx_valid.
REQ-036 PARITY_EN=1, PARITY_ODD=0, data 0x07 with parity bit 0 -> one parity_error pulse, no rx_valid; repeated with parity bit 1 -> rx_data=0x07, rx_valid=1.
REQ-037 nreset pulsed low during the 4th data bit -> all outputs 0 immediately; frame 0x5A sent after release -> rx_data=0x5A, rx_valid=1.
